uart_fifo_bridge: RTL and testbench
===================================

Name: uart_fifo_bridge

Overview:
- Host-side client of the UART's byte interface. It drives the UART transmit handshake (transmit/tx_byte/is_transmitting) and consumes the receive indications (received/rx_byte/recv_error).
- It decouples user logic from UART timing with a TX FIFO and an RX FIFO, both first-word-fall-through, plus overflow and error status.
- It sits between the UART core and the CPU/stream fabric, in the same clock domain as the UART.

Parameters:
- TX_DEPTH_LOG2, 4, TX FIFO depth is 2**TX_DEPTH_LOG2 entries (16).
- RX_DEPTH_LOG2, 4, RX FIFO depth is 2**RX_DEPTH_LOG2 entries (16).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to queue for transmission.
- tx_valid  in  1  push tx_data this cycle if tx_ready.
- tx_ready  out  1  equals TX FIFO not full.
- tx_level  out  TX_DEPTH_LOG2+1  TX FIFO occupancy.
- rx_data  out  8  head of RX FIFO; valid when rx_valid.
- rx_valid  out  1  equals RX FIFO not empty.
- rx_ready  in  1  pop RX head this cycle if rx_valid.
- rx_level  out  RX_DEPTH_LOG2+1  RX FIFO occupancy.
- rx_overflow  out  1  sticky: a received byte was dropped.
- rx_overflow_clr  in  1  clears rx_overflow.
- rx_error_count  out  8  saturating count of uart_recv_error pulses.
- uart_transmit  out  1  to UART transmit.
- uart_tx_byte  out  8  to UART tx_byte; registered.
- uart_is_transmitting  in  1  from UART is_transmitting.
- uart_received  in  1  from UART received (1-cycle pulse).
- uart_rx_byte  in  8  from UART rx_byte; valid with uart_received.
- uart_recv_error  in  1  from UART recv_error (1-cycle pulse).

Behaviour:
- Reset values:
  - tx_ready=1, tx_level=0, rx_valid=0, rx_level=0.
  - rx_data=0, rx_overflow=0, rx_error_count=0.
  - uart_transmit=0, uart_tx_byte=0, TX FSM=TX_IDLE.
  - FIFO pointers cleared and contents discarded.
- Reset mid-operation: uart_transmit drops on the next edge and any byte in flight is abandoned. The UART shares rst, so both ends return to idle together.
- TX FIFO:
  - Push when tx_valid&&tx_ready. tx_valid while full is ignored with no side effect.
  - Pop only from the TX FSM.
- TX FSM, all outputs registered:
  - TX_IDLE: if FIFO not empty && !uart_is_transmitting, then uart_tx_byte<=head, pop, uart_transmit<=1, go TX_REQ.
  - TX_REQ: hold uart_transmit=1 and uart_tx_byte stable. When uart_is_transmitting==1, uart_transmit<=0 and go TX_BUSY.
  - TX_BUSY: when uart_is_transmitting==0, go TX_IDLE.
  - uart_transmit must be low before the UART finishes its stop-bit delay. Dropping it in TX_REQ guarantees exactly one character per request, since the UART waits for transmit low before idling.
  - Latency: first push into an empty FIFO with the UART idle at edge N gives uart_transmit=1 after edge N+2.
  - Back-to-back bytes: the next launch happens the cycle after uart_is_transmitting falls, provided the FIFO is not empty.
- RX FIFO:
  - Push on uart_received, capturing uart_rx_byte.
  - Pop when rx_ready&&rx_valid. rx_ready while empty is ignored.
  - Full with uart_received and a pop in the same cycle: accept the byte. Level is unchanged and there is no overflow.
  - Full with uart_received and no pop: drop the byte and set rx_overflow=1 on the next edge.
  - rx_overflow stays 1 until rx_overflow_clr. If clr and a new overflow occur in the same cycle, set wins.
  - Push and pop together when not full: level unchanged, order preserved.
  - Push into empty: rx_valid=1 and rx_data=byte after the next edge (FWFT, 1-cycle latency).
- rx_error_count: +1 per uart_recv_error cycle; saturates at 255, never wraps. Cleared only by rst.
- Levels: exact occupancy 0..2**DEPTH_LOG2. Pointers are DEPTH_LOG2 bits and wrap modulo depth; full/empty are derived from the level counter.

Decomposition:
- Shared package uart_pkg holds:
  - TX FSM state encoding: 2-bit, TX_IDLE=0, TX_REQ=1, TX_BUSY=2.
  - UART_BYTE_W=8.
  - ERR_CNT_MAX=255.
- One natural sub-module: sync_fifo_fwft (params WIDTH, DEPTH_LOG2; ports push, din, pop, dout, full, empty, level), instantiated twice.
- Top-level RTL keeps the TX FSM, the overflow/error logic and the port glue.

Test Plan:
Bench uses the real UART with sys_clk_freq=160, baud_rate=10, and tx looped back to rx unless stated.
1. Single byte: push 0xA5 at edge N → uart_transmit=1 and uart_tx_byte=0xA5 after edge N+2, held until uart_is_transmitting=1, then 0. tx_level goes 1→0. Loopback gives rx_valid=1 with rx_data=0xA5 and exactly one RX entry.
2. Ordering: push 0x01,0x02,0x03 on consecutive cycles → rx_level reaches 3. Pops return 0x01,0x02,0x03. Exactly 3 uart_transmit rising edges occur.
3. TX full: hold uart_is_transmitting=1 (UART stubbed) and push 17 bytes → tx_ready=0 after the 16th. The 17th push is ignored and tx_level=16. Releasing the stub drains all 16 in order.
4. RX overflow:
   - Stub 17 uart_received pulses (0x10..0x20) without popping → rx_level=16, rx_overflow=1, and popping yields 0x10..0x1F.
   - Pulse rx_overflow_clr → rx_overflow=0.
   - Received while full with a same-cycle pop → accepted, rx_overflow stays 0.
5. Error count: 300 uart_recv_error pulses → rx_error_count=255 and it stays there.
6. Reset mid-send: assert rst while in TX_REQ with tx_level=5 → after one edge uart_transmit=0, tx_level=0, rx_level=0, rx_overflow=0, and no further transmit pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART host-side bridge.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;
  localparam int unsigned ERR_CNT_MAX = 255;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_BUSY = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// User-side streams plus UART byte handshake of the FIFO bridge.
interface uart_fifo_bridge_if #(
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned RX_DEPTH_LOG2 = 4
);
  import uart_pkg::*;

  logic [UART_BYTE_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [TX_DEPTH_LOG2:0] tx_level;
  logic [UART_BYTE_W-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic [RX_DEPTH_LOG2:0] rx_level;
  logic                   rx_overflow;
  logic                   rx_overflow_clr;
  logic [7:0]             rx_error_count;
  logic                   uart_transmit;
  logic [UART_BYTE_W-1:0] uart_tx_byte;
  logic                   uart_is_transmitting;
  logic                   uart_received;
  logic [UART_BYTE_W-1:0] uart_rx_byte;
  logic                   uart_recv_error;

  // Bridge side.
  modport slave (
    input  tx_data, tx_valid, rx_ready, rx_overflow_clr,
    input  uart_is_transmitting, uart_received, uart_rx_byte, uart_recv_error,
    output tx_ready, tx_level, rx_data, rx_valid, rx_level, rx_overflow, rx_error_count,
    output uart_transmit, uart_tx_byte
  );

  // User logic / UART side.
  modport master (
    output tx_data, tx_valid, rx_ready, rx_overflow_clr,
    output uart_is_transmitting, uart_received, uart_rx_byte, uart_recv_error,
    input  tx_ready, tx_level, rx_data, rx_valid, rx_level, rx_overflow, rx_error_count,
    input  uart_transmit, uart_tx_byte
  );

endinterface

// File: rtl/uart_fifo_bridge_fifo.sv
// First-word-fall-through synchronous FIFO; full/empty derive from an exact level counter.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [Depth];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push, do_pop;

  assign full    = (cnt == (DEPTH_LOG2 + 1)'(Depth));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  // Stale storage is masked so the head reads zero while empty.
  assign dout    = empty ? '0 : mem[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Host-side UART client: TX/RX FIFOs, transmit handshake FSM, overflow and error status.
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned RX_DEPTH_LOG2 = 4
) (
  input logic              clk,
  input logic              rst,
  uart_fifo_bridge_if.slave bus
);

  logic [UART_BYTE_W-1:0] tx_head;
  logic                   tx_full, tx_empty, tx_pop;
  logic                   rx_full, rx_empty, rx_pop_ok, ovf_set;
  tx_state_e              state;
  logic                   transmit_q;
  logic [UART_BYTE_W-1:0] tx_byte_q;
  logic                   overflow_q;
  logic [7:0]             err_cnt_q;

  sync_fifo_fwft #(
    .WIDTH      (UART_BYTE_W),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.tx_valid && !tx_full),
    .din   (bus.tx_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (bus.tx_level)
  );

  sync_fifo_fwft #(
    .WIDTH      (UART_BYTE_W),
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.uart_received),
    .din   (bus.uart_rx_byte),
    .pop   (bus.rx_ready),
    .dout  (bus.rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (bus.rx_level)
  );

  assign tx_pop    = (state == TX_IDLE) && !tx_empty && !bus.uart_is_transmitting;
  assign rx_pop_ok = bus.rx_ready && !rx_empty;
  assign ovf_set   = bus.uart_received && rx_full && !rx_pop_ok;

  assign bus.tx_ready       = !tx_full;
  assign bus.rx_valid       = !rx_empty;
  assign bus.rx_overflow    = overflow_q;
  assign bus.rx_error_count = err_cnt_q;
  assign bus.uart_transmit  = transmit_q;
  assign bus.uart_tx_byte   = tx_byte_q;

  // Transmit handshake: request, drop request once the UART is busy, wait for it to finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= TX_IDLE;
      transmit_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_byte_q  <= tx_head;
            transmit_q <= 1'b1;
            state      <= TX_REQ;
          end
        end
        TX_REQ: begin
          // Releasing transmit here yields exactly one character per request.
          if (bus.uart_is_transmitting) begin
            transmit_q <= 1'b0;
            state      <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (!bus.uart_is_transmitting) state <= TX_IDLE;
        end
        default: begin
          transmit_q <= 1'b0;
          state      <= TX_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                      overflow_q <= 1'b0;
    else if (ovf_set)             overflow_q <= 1'b1;
    else if (bus.rx_overflow_clr) overflow_q <= 1'b0;
  end

  // Saturating receive-error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (bus.uart_recv_error && (err_cnt_q != 8'(ERR_CNT_MAX))) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with a behavioural UART loopback stub.
module tb_uart_fifo_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_fifo_bridge_if #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) bus ();

  uart_fifo_bridge #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // UART stub: accepts a request, stays busy 8 cycles, then loops the byte back.
  logic       stub_en = 1'b0;
  logic       hold_busy = 1'b0;
  logic       stub_busy, stub_rcv;
  logic [7:0] stub_rx;
  int         stub_cnt;
  logic       man_rcv = 1'b0;
  logic [7:0] man_byte = 8'h00;

  assign bus.uart_is_transmitting = stub_busy | hold_busy;
  assign bus.uart_received        = stub_rcv | man_rcv;
  assign bus.uart_rx_byte         = stub_rcv ? stub_rx : man_byte;

  always @(posedge clk) begin
    stub_rcv <= 1'b0;
    if (rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_rx   <= 8'h00;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_busy <= 1'b0;
        stub_rcv  <= 1'b1;
      end
    end else if (stub_en && bus.uart_transmit && !stub_busy && !hold_busy) begin
      stub_busy <= 1'b1;
      stub_rx   <= bus.uart_tx_byte;
      stub_cnt  <= 8;
    end
  end

  // Count rising edges of uart_transmit.
  logic tx_prev = 1'b0;
  int   tx_rises = 0;
  always @(posedge clk) begin
    tx_prev <= bus.uart_transmit;
    if (bus.uart_transmit && !tx_prev) tx_rises <= tx_rises + 1;
  end

  typedef struct {
    logic       rcv;
    logic [7:0] b;
    logic       pop;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] el;
    logic       eo;
  } rx_vec_t;

  rx_vec_t vecs[$];

  task automatic add(input logic rcv, input logic [7:0] b, input logic pop, input logic clr,
                     input logic ev, input logic [7:0] ed, input logic [4:0] el,
                     input logic eo);
    rx_vec_t v;
    v.rcv = rcv; v.b = b; v.pop = pop; v.clr = clr;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rx_level(input int lvl, input int budget, input string name);
    int n = 0;
    while (int'(bus.rx_level) != lvl && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(bus.rx_level), 32'(lvl));
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string name);
    check(name, {23'd0, bus.rx_valid, bus.rx_data}, {23'd0, 1'b1, exp});
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rx_overflow_clr = 1'b0;
    bus.uart_recv_error = 1'b0;

    // RX table: 17 receptions into 16 slots, clear/set priority, full push+pop, drain.
    for (int i = 0; i < 17; i++) begin
      add(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1, 8'h10, 5'((i < 16) ? i + 1 : 16), i == 16);
    end
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h10, 5'd16, 1'b0);
    add(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h10, 5'd16, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h10, 5'd16, 1'b0);
    add(1'b1, 8'h21, 1'b1, 1'b0, 1'b1, 8'h11, 5'd16, 1'b0);
    for (int j = 0; j < 16; j++) begin
      add(1'b0, 8'h00, 1'b1, 1'b0, j < 15, (j < 14) ? 8'(8'h12 + j) : ((j == 14) ? 8'h21 : 8'h00),
          5'(15 - j), 1'b0);
    end
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0);
    add(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0);
    add(1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 5'd1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0);

    // Reset state.
    step();
    step();
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_tx_level", 32'(bus.tx_level), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_level", 32'(bus.rx_level), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_overflow", 32'(bus.rx_overflow), 32'd0);
    check("rst_err_count", 32'(bus.rx_error_count), 32'd0);
    check("rst_transmit", 32'(bus.uart_transmit), 32'd0);
    check("rst_tx_byte", 32'(bus.uart_tx_byte), 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      man_rcv = vecs[i].rcv;
      man_byte = vecs[i].b;
      bus.rx_ready = vecs[i].pop;
      bus.rx_overflow_clr = vecs[i].clr;
      step();
      man_rcv = 1'b0;
      bus.rx_ready = 1'b0;
      bus.rx_overflow_clr = 1'b0;
      check($sformatf("rxvec%0d_valid", i), 32'(bus.rx_valid), 32'(vecs[i].ev));
      check($sformatf("rxvec%0d_data", i), 32'(bus.rx_data), 32'(vecs[i].ed));
      check($sformatf("rxvec%0d_level", i), 32'(bus.rx_level), 32'(vecs[i].el));
      check($sformatf("rxvec%0d_ovf", i), 32'(bus.rx_overflow), 32'(vecs[i].eo));
    end

    // Single byte with loopback; tx_valid driven after edge N.
    stub_en = 1'b1;
    base = tx_rises;
    bus.tx_data = 8'hA5;
    bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
    check("t1_level_after_push", 32'(bus.tx_level), 32'd1);
    check("t1_transmit_n1", 32'(bus.uart_transmit), 32'd0);
    step();
    check("t1_transmit_n2", 32'(bus.uart_transmit), 32'd1);
    check("t1_tx_byte", 32'(bus.uart_tx_byte), 32'hA5);
    check("t1_level_after_pop", 32'(bus.tx_level), 32'd0);
    step();
    check("t1_transmit_held", {bus.uart_transmit, bus.uart_is_transmitting}, 32'b11);
    step();
    check("t1_transmit_dropped", 32'(bus.uart_transmit), 32'd0);
    check("t1_tx_byte_stable", 32'(bus.uart_tx_byte), 32'hA5);
    wait_rx_level(1, 60, "t1_rx_arrival");
    check("t1_rx_data", 32'(bus.rx_data), 32'hA5);
    repeat (20) step();
    check("t1_one_entry", 32'(bus.rx_level), 32'd1);
    check("t1_one_request", 32'(tx_rises - base), 32'd1);
    pop_expect(8'hA5, "t1_pop");
    check("t1_rx_empty", 32'(bus.rx_level), 32'd0);

    // Ordering of three consecutive pushes.
    base = tx_rises;
    for (int i = 1; i <= 3; i++) begin
      bus.tx_data = 8'(i);
      bus.tx_valid = 1'b1;
      step();
    end
    bus.tx_valid = 1'b0;
    wait_rx_level(3, 200, "t2_rx_level");
    for (int i = 1; i <= 3; i++) pop_expect(8'(i), $sformatf("t2_pop%0d", i));
    check("t2_rises", 32'(tx_rises - base), 32'd3);

    // TX full: UART held busy, 17 pushes.
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.tx_data = 8'(8'hB0 + i);
      bus.tx_valid = 1'b1;
      step();
      if (i == 15) check("t3_ready_after16", 32'(bus.tx_ready), 32'd0);
    end
    bus.tx_valid = 1'b0;
    check("t3_level16", 32'(bus.tx_level), 32'd16);
    hold_busy = 1'b0;
    wait_rx_level(16, 1000, "t3_drained");
    check("t3_tx_empty", 32'(bus.tx_level), 32'd0);
    check("t3_no_ovf", 32'(bus.rx_overflow), 32'd0);
    for (int i = 0; i < 16; i++) pop_expect(8'(8'hB0 + i), $sformatf("t3_pop%0d", i));
    repeat (20) step();
    check("t3_no_17th", 32'(bus.rx_level), 32'd0);

    // Error counter saturation.
    bus.uart_recv_error = 1'b1;
    step();
    bus.uart_recv_error = 1'b0;
    check("t5_err_one", 32'(bus.rx_error_count), 32'd1);
    bus.uart_recv_error = 1'b1;
    repeat (253) step();
    bus.uart_recv_error = 1'b0;
    check("t5_err_254", 32'(bus.rx_error_count), 32'd254);
    bus.uart_recv_error = 1'b1;
    repeat (46) step();
    bus.uart_recv_error = 1'b0;
    check("t5_err_sat", 32'(bus.rx_error_count), 32'd255);

    // Reset while stuck in TX_REQ with five bytes still queued.
    stub_en = 1'b0;
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.tx_data = 8'(8'hC0 + i);
      bus.tx_valid = 1'b1;
      step();
    end
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      man_rcv = 1'b1;
      man_byte = 8'(8'hD0 + i);
      step();
    end
    man_rcv = 1'b0;
    hold_busy = 1'b0;
    n = 0;
    while (!bus.uart_transmit && n < 10) begin
      step();
      n++;
    end
    check("t6_in_req", 32'(bus.uart_transmit), 32'd1);
    check("t6_level5", 32'(bus.tx_level), 32'd5);
    check("t6_rx_before", 32'(bus.rx_level), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_transmit", 32'(bus.uart_transmit), 32'd0);
    check("t6_tx_level", 32'(bus.tx_level), 32'd0);
    check("t6_rx_level", 32'(bus.rx_level), 32'd0);
    check("t6_ovf", 32'(bus.rx_overflow), 32'd0);
    check("t6_err", 32'(bus.rx_error_count), 32'd0);
    check("t6_tx_ready", 32'(bus.tx_ready), 32'd1);
    stub_en = 1'b1;
    base = tx_rises;
    repeat (40) step();
    check("t6_no_transmit", 32'(tx_rises - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
